sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO buffer: write port, read port, occupancy count, programmable almost-full/almost-empty thresholds, sticky-free overflow/underflow pulses, selectable standard or first-word-fall-through read mode. Next-generation replacement for the bare storage array in our FIFO designs; used wherever producer and consumer share one clock domain. Register-array storage.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 16, entry count; power of two, ≥ 2
- PTR_WIDTH, $clog2(DEPTH), address width; pointers are PTR_WIDTH+1 bits
- AF_LEVEL, DEPTH-2, almost_full when count ≥ AF_LEVEL; legal 1..DEPTH
- AE_LEVEL, 2, almost_empty when count ≤ AE_LEVEL; legal 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request (FWFT: pop/acknowledge head)
- data_out  out  DATA_WIDTH  read data
- full, empty  out  1  count == DEPTH / count == 0
- almost_full, almost_empty  out  1  threshold flags
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  one-cycle error pulses

## Operation
- Write accepted (wr_acc) = w_en & !full; stores data_in at wptr[PTR_WIDTH-1:0], wptr += 1.
- Read accepted (rd_acc) = r_en & !empty; rptr += 1.
- Acceptance uses flags registered before the edge: full + w_en + r_en → read only; empty + w_en + r_en → write only.
- Pointers wrap modulo 2·DEPTH; address = low PTR_WIDTH bits. count register: count + wr_acc − rd_acc, never outside 0..DEPTH.
- full, empty, almost_full, almost_empty decoded from the registered count.
- overflow registered: 1 for one cycle after an edge where w_en & full; underflow likewise for r_en & empty. Rejected request changes no state.
- FWFT=0: data_out register loads mem[rptr] on rd_acc edge, otherwise holds.
- FWFT=1: data_out = empty ? 0 : mem[rptr] (head word); r_en pops it.
- Memory contents not reset; unread data never visible.
- Reset values: wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL ≥ 1), overflow=underflow=0, data_out=0.
- rst mid-operation discards all contents; rst dominates w_en/r_en the same edge.

## Timing
- Write at edge k → count/empty/flags updated after edge k.
- FWFT=1: written word on data_out after edge k (into empty FIFO) → 1-cycle write-to-data latency.
- FWFT=0: r_en earliest at edge k+1; data_out valid after k+1 → 2-cycle latency; read data 1 cycle after rd_acc edge.
- Sustained simultaneous wr_acc & rd_acc: count constant, full throughput 1 word/cycle each side.
- Flags and pulses change only at clk edges; no combinational path w_en/r_en → any output.

## Structure
- Shared package fifo_pkg: mode constants (FIFO_STD=0, FIFO_FWFT=1), pointer-width function, threshold legality check macros; reused by the dual-clock FIFO.
- Sub-module sync_fifo_ram: DEPTH×DATA_WIDTH array, synchronous write port, asynchronous read port; top holds pointers, count, flags, data_out register, mode mux.
- Elaboration-time error for illegal DEPTH, AF_LEVEL, AE_LEVEL.

## Test plan
- Reset: assert rst 2 cycles during traffic → count=0, empty=1, almost_empty=1, full=0, data_out=0, pulses 0.
- Fill/drain, DEPTH=16, FWFT=0: write 0x00..0x0F → full=1, count=16, almost_full from count=14; read 16 → data_out 0x00..0x0F in order, each one cycle after r_en, empty=1 at end.
- Overflow/underflow: w_en with full → overflow=1 one cycle, count stays 16, no overwrite; r_en with empty → underflow=1 one cycle, data_out unchanged.
- Simultaneous: full + w_en + r_en → read only, count=15; empty + w_en + r_en → write only, count=1; count=8 + both → count stays 8 for 40 cycles, order preserved across pointer wrap.
- FWFT=1: write 0xA5 into empty → data_out=0xA5 next cycle without r_en; r_en → next word or 0 when empty.
- Thresholds: AF_LEVEL=12, AE_LEVEL=3 → almost_full toggles exactly at count 11↔12, almost_empty at 3↔4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, pointer sizing and parameter legality checks.
// Used by both the single-clock and the dual-clock FIFO.
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_DEPTH_LEGAL(d)       (((d) >= 2) && (((d) & ((d) - 1)) == 0))
`define FIFO_AF_LEGAL(af, d)      (((af) >= 1) && ((af) <= (d)))
`define FIFO_AE_LEGAL(ae, d)      (((ae) >= 0) && ((ae) <= ((d) - 1)))
`endif

package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit depth_legal(input int depth);
        return `FIFO_DEPTH_LEGAL(depth);
    endfunction

    function automatic bit af_legal(input int af_level, input int depth);
        return `FIFO_AF_LEGAL(af_level, depth);
    endfunction

    function automatic bit ae_legal(input int ae_level, input int depth);
        return `FIFO_AE_LEGAL(ae_level, depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, contents never reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses and
// selectable standard / first-word-fall-through read mode.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = ptr_width(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
        if (!af_legal(AF_LEVEL, DEPTH)) begin : g_bad_af
            $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
        end
        if (!ae_legal(AE_LEVEL, DEPTH)) begin : g_bad_ae
            $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [PTR_WIDTH:0]    wptr_reg;
    logic [PTR_WIDTH:0]    rptr_reg;
    logic [PTR_WIDTH:0]    count_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head_data;

    // Flags come straight from the registered count, so no input reaches an output combinationally.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_reg[PTR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (rptr_reg[PTR_WIDTH-1:0]),
        .rdata (head_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (rd_acc) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_reg <= count_reg + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_reg <= count_reg - 1'b1;
            end
            overflow_reg  <= w_en & full;
            underflow_reg <= r_en & empty;
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; zero masks stale memory when nothing is queued.
            assign data_out = empty ? '0 : head_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_reg <= '0;
                end else if (rd_acc) begin
                    data_out_reg <= head_data;
                end
            end

            assign data_out = data_out_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF_A  = 14;
    localparam int AE_A  = 2;
    localparam int AF_B  = 12;
    localparam int AE_B  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic          full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [4:0]    count_a, count_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_std_dout = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_A), .AE_LEVEL(AE_A), .FWFT(0)) dut_std (
        .clk (clk), .rst (rst), .w_en (w_en), .data_in (data_in), .r_en (r_en),
        .data_out (dout_a), .full (full_a), .empty (empty_a), .almost_full (af_a),
        .almost_empty (ae_a), .count (count_a), .overflow (ovf_a), .underflow (unf_a)
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_B), .AE_LEVEL(AE_B), .FWFT(1)) dut_fwft (
        .clk (clk), .rst (rst), .w_en (w_en), .data_in (data_in), .r_en (r_en),
        .data_out (dout_b), .full (full_b), .empty (empty_b), .almost_full (af_b),
        .almost_empty (ae_b), .count (count_b), .overflow (ovf_b), .underflow (unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] exp_head;
        n = q.size();
        exp_head = (n > 0) ? q[0] : '0;
        check("std_count",   32'(count_a), 32'(n));
        check("std_full",    32'(full_a),  32'(n == DEPTH));
        check("std_empty",   32'(empty_a), 32'(n == 0));
        check("std_afull",   32'(af_a),    32'(n >= AF_A));
        check("std_aempty",  32'(ae_a),    32'(n <= AE_A));
        check("std_ovf",     32'(ovf_a),   32'(exp_ovf));
        check("std_unf",     32'(unf_a),   32'(exp_unf));
        check("std_dout",    32'(dout_a),  32'(exp_std_dout));
        check("fwft_count",  32'(count_b), 32'(n));
        check("fwft_full",   32'(full_b),  32'(n == DEPTH));
        check("fwft_empty",  32'(empty_b), 32'(n == 0));
        check("fwft_afull",  32'(af_b),    32'(n >= AF_B));
        check("fwft_aempty", 32'(ae_b),    32'(n <= AE_B));
        check("fwft_ovf",    32'(ovf_b),   32'(exp_ovf));
        check("fwft_unf",    32'(unf_b),   32'(exp_unf));
        check("fwft_dout",   32'(dout_b),  32'(exp_head));
    endtask

    // One clock cycle: drive, advance the reference model across the edge, compare.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        int n;
        w_en = w;
        r_en = r;
        data_in = d;
        rst = rs;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            exp_std_dout = '0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = w && (n == DEPTH);
            exp_unf = r && (n == 0);
            if (r && n > 0) begin
                exp_std_dout = q.pop_front();
            end
            if (w && n < DEPTH) begin
                q.push_back(d);
            end
        end
        #1;
        $display("cycle rst=%0b w=%0b r=%0b din=%02h count=%0d dout_std=%02h dout_fwft=%02h",
                 rs, w, r, d, count_a, dout_a, dout_b);
        check_all();
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill 0x00..0x0F, then overflow attempt
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Full + both: read only
        step(1'b1, 1'b1, 8'h77, 1'b0);

        // Drain, then underflow attempts
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Empty + both: write only; FWFT head appears without r_en
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Count 8 then sustained simultaneous traffic across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);

        // Random traffic with varying read/write bias
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
            step(1'($urandom_range(99) < wp), 1'($urandom_range(99) < (100 - wp)),
                 8'($urandom), 1'b0);
        end

        // Reset during traffic
        step(1'b1, 1'b1, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
